// File: rtl/bf1.sv
// First-stage radix-2 butterfly: registered, saturating sum and difference of
// one signed Q4.12 input pair per clock.
module bf1 #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] x_0_re,
    input  logic [DATA_W-1:0] x_1_re,
    output logic [DATA_W-1:0] g_0_re,
    output logic [DATA_W-1:0] g_1_re
);

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // FRAC_W only documents the format; reject nonsensical values at elaboration.
    if (FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_bad_frac_w
        $error("bf1: FRAC_W must lie in [0, DATA_W)");
    end

    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [DATA_W-1:0] sum_sat;
    logic [DATA_W-1:0] diff_sat;

    function automatic logic [DATA_W-1:0] saturate(input logic [DATA_W:0] v);
        if (v[DATA_W] != v[DATA_W-1])
            return v[DATA_W] ? SAT_MIN : SAT_MAX;
        else
            return v[DATA_W-1:0];
    endfunction

    // One guard bit makes the full-precision add/subtract exact.
    always_comb begin
        sum_ext  = {x_0_re[DATA_W-1], x_0_re} + {x_1_re[DATA_W-1], x_1_re};
        diff_ext = {x_0_re[DATA_W-1], x_0_re} - {x_1_re[DATA_W-1], x_1_re};
        sum_sat  = saturate(sum_ext);
        diff_sat = saturate(diff_ext);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g_0_re <= '0;
            g_1_re <= '0;
        end else begin
            g_0_re <= sum_sat;
            g_1_re <= diff_sat;
        end
    end

endmodule

// File: tb/tb_bf1.sv
// Self-checking bench for bf1: directed vectors, asynchronous reset checks and
// random streaming against an integer-arithmetic saturating model.
module tb_bf1;

    localparam int DATA_W = 16;
    localparam int SAT_HI = (1 << (DATA_W - 1)) - 1;
    localparam int SAT_LO = -(1 << (DATA_W - 1));

    logic              clk;
    logic              reset_n;
    logic [DATA_W-1:0] x_0_re;
    logic [DATA_W-1:0] x_1_re;
    logic [DATA_W-1:0] g_0_re;
    logic [DATA_W-1:0] g_1_re;

    int n_checks = 0;
    int n_fail   = 0;

    bf1 #(.DATA_W(DATA_W), .FRAC_W(12)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .x_0_re  (x_0_re),
        .x_1_re  (x_1_re),
        .g_0_re  (g_0_re),
        .g_1_re  (g_1_re)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: true signed integer result clamped to the DATA_W range.
    function automatic logic [DATA_W-1:0] clamp(input int v);
        int c;
        c = (v > SAT_HI) ? SAT_HI : (v < SAT_LO) ? SAT_LO : v;
        return c[DATA_W-1:0];
    endfunction

    function automatic int to_int(input logic [DATA_W-1:0] x);
        return int'($signed(x));
    endfunction

    // Drive a pair at the falling edge (after a glitch burst), check one edge later.
    task automatic apply(input string tag, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] e0, e1;
        @(negedge clk);
        x_0_re = DATA_W'($urandom);
        x_1_re = DATA_W'($urandom);
        #1;
        x_0_re = ~a;
        #1;
        x_0_re = a;
        x_1_re = b;
        e0 = clamp(to_int(a) + to_int(b));
        e1 = clamp(to_int(a) - to_int(b));
        @(posedge clk);
        #1;
        check({tag, "_g0"}, g_0_re, e0);
        check({tag, "_g1"}, g_1_re, e1);
    endtask

    initial begin
        logic [DATA_W-1:0] ra, rb;

        reset_n = 1'b0;
        x_0_re  = 16'h1234;
        x_1_re  = 16'h0F0F;
        #2;
        check("rst_noclk_g0", g_0_re, 16'h0000);
        check("rst_noclk_g1", g_1_re, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_clk_g0", g_0_re, 16'h0000);
        check("rst_clk_g1", g_1_re, 16'h0000);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // Directed vectors with hand-derived expectations.
        apply("nominal", 16'h0199, 16'hFCCD);
        check("nominal_g0_c", g_0_re, 16'hFE66);
        check("nominal_g1_c", g_1_re, 16'h04CC);
        apply("b2b", 16'hFB34, 16'hFCCD);
        check("b2b_g0_c", g_0_re, 16'hF801);
        check("b2b_g1_c", g_1_re, 16'hFE67);
        @(negedge clk);
        check("b2b_hold_g0", g_0_re, 16'hF801);
        check("b2b_hold_g1", g_1_re, 16'hFE67);
        apply("pos_sat", 16'h7000, 16'h2000);
        check("pos_sat_g0_c", g_0_re, 16'h7FFF);
        check("pos_sat_g1_c", g_1_re, 16'h5000);
        apply("neg_sat", 16'h8000, 16'h7FFF);
        check("neg_sat_g0_c", g_0_re, 16'hFFFF);
        check("neg_sat_g1_c", g_1_re, 16'h8000);
        apply("min_min", 16'h8000, 16'h8000);
        check("min_min_g0_c", g_0_re, 16'h8000);
        check("min_min_g1_c", g_1_re, 16'h0000);

        // Asynchronous reset pulse between edges, then a normal capture.
        apply("pre_rst", 16'h0199, 16'hFCCD);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_g0", g_0_re, 16'h0000);
        check("async_rst_g1", g_1_re, 16'h0000);
        #1 reset_n = 1'b1;
        apply("post_rst", 16'h0FFF, 16'hF001);

        for (int i = 0; i < 1000; i++) begin
            ra = DATA_W'($urandom);
            rb = DATA_W'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 16'h7FFF;
                1: rb = 16'h8000;
                2: begin ra = 16'h8000; rb = 16'h7FFF; end
                default: ;
            endcase
            apply("rand", ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
